uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 63 ++++++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Shared definitions for the UART receiver:
//   rx_state_e   - receiver FSM state enumeration
//   EVEN / ODD   - Parity_Typ encodings
//   PRESCALE_*   - the legal Prescale (Clk cycles per bit) values
//   majority3()  - 2-of-3 vote used by the bit sampler
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Module: uart_rx_sampler
// Per-bit timing for the UART receiver: an edge counter running 0..prescale-1
// within each bit period and a 3-sample majority voter around mid-bit.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   start     - start bit detected this cycle; this cycle is edge count 0
//   enable    - a frame is in progress (FSM not idle)
//   rx        - synchronized serial line
//   prescale  - Clk cycles per bit, held constant for the frame
//   bit_val   - majority vote of the samples of the current bit
//   bit_done  - strobe on the last edge count of a bit period
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic       rx,
  input  logic [5:0] prescale,
  output logic       bit_val,
  output logic       bit_done
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [5:0] last_cnt;
  logic [2:0] samples;

  assign half     = {1'b0, prescale[5:1]};
  assign last_cnt = prescale - 6'd1;
  assign bit_done = enable && (edge_cnt == last_cnt);

  // The third sample lands at half+1, which is always before the last edge
  // count for the legal prescales, so the vote is stable when bit_done fires.
  assign bit_val = majority3(samples[0], samples[1], samples[2]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else begin
      // The detection cycle already counts as edge 0 of the start bit, so the
      // count resumes at 1 and the frame ends exactly on the bit grid.
      if (start) begin
        edge_cnt <= 6'd1;
      end else if (bit_done || !enable) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end

      if (enable) begin
        if (edge_cnt == half - 6'd1) samples[0] <= rx;
        if (edge_cnt == half)        samples[1] <= rx;
        if (edge_cnt == half + 6'd1) samples[2] <= rx;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Module: uart_rx
// UART receiver: start bit, DATA_WD data bits LSB first, optional parity bit,
// one stop bit. Frame settings are latched when the start bit is detected.
// Ports:
//   Clk, Rst    - clock and asynchronous active-high reset
//   RX_IN       - serial line, idles high
//   Prescale    - Clk cycles per bit (8, 16 or 32)
//   Parity_En   - a parity bit follows the data bits
//   Parity_Typ  - 0 even, 1 odd
//   P_Data      - last correctly received word
//   Data_Valid  - one-cycle pulse when P_Data is updated
//   Parity_Err  - one-cycle pulse for a frame with bad parity
//   Stop_Err    - one-cycle pulse for a frame whose stop bit was 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               RX_IN,
  input  logic [5:0]         Prescale,
  input  logic               Parity_En,
  input  logic               Parity_Typ,
  output logic [DATA_WD-1:0] P_Data,
  output logic               Data_Valid,
  output logic               Parity_Err,
  output logic               Stop_Err
);

  localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(DATA_WD - 1);

  logic [1:0]         sync_q;
  logic               rx_s;
  rx_state_e          state_q;
  rx_state_e          state_d;
  logic               start_det;
  logic               bit_val;
  logic               bit_done;
  logic [5:0]         prescale_q;
  logic               par_en_q;
  logic               par_typ_q;
  logic               par_err_q;
  logic               expected_par;
  logic [CNT_WD-1:0]  bit_cnt;
  logic [DATA_WD-1:0] shift_reg;

  // Two-flop synchronizer; reset to the idle-high line level so reset release
  // never looks like a start bit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign rx_s      = sync_q[1];
  assign start_det = (state_q == IDLE) && !rx_s;

  uart_rx_sampler u_sampler (
    .clk      (Clk),
    .rst      (Rst),
    .start    (start_det),
    .enable   (state_q != IDLE),
    .rx       (rx_s),
    .prescale (prescale_q),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is given a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (bit_done) state_d = bit_val ? IDLE : DATA;
      DATA:    if (bit_done && (bit_cnt == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Even parity expects XOR of the data, odd expects its complement.
  assign expected_par = (^shift_reg) ^ (par_typ_q == ODD);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prescale_q <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= EVEN;
      par_err_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      P_Data     <= '0;
      Data_Valid <= 1'b0;
      Parity_Err <= 1'b0;
      Stop_Err   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Parity_Err <= 1'b0;
      Stop_Err   <= 1'b0;

      if (start_det) begin
        prescale_q <= Prescale;
        par_en_q   <= Parity_En;
        par_typ_q  <= Parity_Typ;
        par_err_q  <= 1'b0;
        bit_cnt    <= '0;
      end

      if (bit_done) begin
        case (state_q)
          DATA: begin
            // LSB arrives first, so bits enter at the top and shift down.
            shift_reg <= {bit_val, shift_reg[DATA_WD-1:1]};
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
          PARITY: par_err_q <= (bit_val != expected_par);
          STOP: begin
            Stop_Err   <= !bit_val;
            Parity_Err <= par_err_q;
            if (bit_val && !par_err_q) begin
              P_Data     <= shift_reg;
              Data_Valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench: tb_uart_rx
// Directed scenarios for uart_rx with hand-computed expected words.
module tb_uart_rx;
  import uart_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = PRESCALE_8;
  logic       Parity_En = 1'b0;
  logic       Parity_Typ = EVEN;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Parity_Err;
  logic       Stop_Err;

  int tests_run = 0;
  int tests_failed = 0;

  // Pulse monitor, sampled on the falling edge away from the active edge.
  int         cyc = 0;
  int         dv_cnt = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;
  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];

  uart_rx #(.DATA_WD(8)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .Parity_En  (Parity_En),
    .Parity_Typ (Parity_Typ),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .Parity_Err (Parity_Err),
    .Stop_Err   (Stop_Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Data_Valid) begin
      dv_cnt++;
      dv_data_q.push_back(P_Data);
      dv_cyc_q.push_back(cyc);
    end
    if (Parity_Err) pe_cnt++;
    if (Stop_Err) se_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_cfg(input logic [5:0] pre, input logic en, input logic typ);
    Prescale   = pre;
    Parity_En  = en;
    Parity_Typ = typ;
  endtask

  task automatic drive_bit(input logic b, input logic [5:0] pre);
    RX_IN = b;
    repeat (int'(pre)) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [5:0] pre,
                            input logic par_en, input logic par_bit, input logic stop_bit);
    drive_bit(1'b0, pre);
    for (int i = 0; i < 8; i++) drive_bit(data[i], pre);
    if (par_en) drive_bit(par_bit, pre);
    drive_bit(stop_bit, pre);
    RX_IN = 1'b1;
  endtask

  task automatic expect_int(input string name, input int actual, input int required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic expect_byte(input string name, input logic [7:0] actual, input logic [7:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, actual, required);
    end
  endtask

  task automatic test_reset();
    idle(3);
    Rst = 1'b0;
    idle(2);
    expect_byte("reset P_Data", P_Data, 8'h00);
    expect_int("reset Data_Valid", int'(Data_Valid), 0);
    expect_int("reset Parity_Err", int'(Parity_Err), 0);
    expect_int("reset Stop_Err", int'(Stop_Err), 0);
  endtask

  task automatic test_no_parity();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    set_cfg(PRESCALE_8, 1'b0, EVEN);
    idle(2);
    send_frame(8'hA3, PRESCALE_8, 1'b0, 1'b0, 1'b1);
    idle(6);
    expect_int("nopar dv count", dv_cnt - dv0, 1);
    expect_byte("nopar P_Data", P_Data, 8'hA3);
    expect_int("nopar parity err count", pe_cnt - pe0, 0);
    expect_int("nopar stop err count", se_cnt - se0, 0);
  endtask

  task automatic test_even_parity();
    int dv0, pe0;
    set_cfg(PRESCALE_16, 1'b1, EVEN);
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'hB4, PRESCALE_16, 1'b1, 1'b0, 1'b1);
    idle(6);
    expect_int("even good dv count", dv_cnt - dv0, 1);
    expect_byte("even good P_Data", P_Data, 8'hB4);
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'hB4, PRESCALE_16, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_int("even bad parity err count", pe_cnt - pe0, 1);
    expect_int("even bad dv count", dv_cnt - dv0, 0);
    expect_byte("even bad P_Data held", P_Data, 8'hB4);
  endtask

  task automatic test_odd_parity_stop_err();
    int dv0, pe0, se0;
    set_cfg(PRESCALE_32, 1'b1, ODD);
    idle(2);
    dv0 = dv_cnt;
    send_frame(8'hD2, PRESCALE_32, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_int("odd good dv count", dv_cnt - dv0, 1);
    expect_byte("odd good P_Data", P_Data, 8'hD2);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h0F, PRESCALE_32, 1'b1, 1'b1, 1'b0);
    idle(6);
    expect_int("stop err count", se_cnt - se0, 1);
    expect_int("stop err parity err count", pe_cnt - pe0, 0);
    expect_int("stop err dv count", dv_cnt - dv0, 0);
    expect_byte("stop err P_Data held", P_Data, 8'hD2);
  endtask

  task automatic test_glitch();
    int dv0, pe0, se0;
    set_cfg(PRESCALE_16, 1'b0, EVEN);
    idle(4);
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(5);
    tests_run++;
    if (dut.state_q !== START) begin
      tests_failed++;
      $display("FAIL glitch enters START: got state %0d, expected %0d", dut.state_q, START);
    end
    idle(12);
    tests_run++;
    if (dut.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL glitch back to IDLE: got state %0d, expected %0d", dut.state_q, IDLE);
    end
    idle(4);
    expect_int("glitch pulse count", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
  endtask

  task automatic test_back_to_back();
    int dv0;
    set_cfg(PRESCALE_8, 1'b0, EVEN);
    idle(2);
    dv0 = dv_cnt;
    dv_data_q.delete();
    dv_cyc_q.delete();
    send_frame(8'h55, PRESCALE_8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, PRESCALE_8, 1'b0, 1'b0, 1'b1);
    idle(6);
    expect_int("b2b dv count", dv_cnt - dv0, 2);
    if (dv_data_q.size() == 2) begin
      expect_byte("b2b first word", dv_data_q[0], 8'h55);
      expect_byte("b2b second word", dv_data_q[1], 8'hAA);
      expect_int("b2b pulse spacing", dv_cyc_q[1] - dv_cyc_q[0], 80);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    logic [7:0] data = 8'h81;
    set_cfg(PRESCALE_8, 1'b0, EVEN);
    idle(2);
    drive_bit(1'b0, PRESCALE_8);
    for (int i = 0; i < 4; i++) drive_bit(data[i], PRESCALE_8);
    RX_IN = data[4];
    idle(4);
    #2;
    Rst = 1'b1;
    #1;
    expect_byte("midrst P_Data", P_Data, 8'h00);
    expect_int("midrst outputs", int'({Data_Valid, Parity_Err, Stop_Err}), 0);
    RX_IN = 1'b1;
    idle(3);
    Rst = 1'b0;
    idle(4);
    expect_int("midrst pulse count", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    dv0 = dv_cnt;
    send_frame(8'h3C, PRESCALE_8, 1'b0, 1'b0, 1'b1);
    idle(6);
    expect_int("after rst dv count", dv_cnt - dv0, 1);
    expect_byte("after rst P_Data", P_Data, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_even_parity();
    test_odd_parity_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
